// File: rtl/tlc_pkg.sv
// Shared state codes and lamp encodings for the two-approach traffic light controller.
package tlc_pkg;

  typedef enum logic [2:0] {
    MAIN_G  = 3'd0,
    MAIN_Y  = 3'd1,
    ALLRED1 = 3'd2,
    SIDE_G  = 3'd3,
    SIDE_Y  = 3'd4,
    ALLRED2 = 3'd5,
    WALK    = 3'd6
  } tlc_state_e;

  // Lamp head encoding {R,G,Y}
  localparam logic [2:0] LT_RED    = 3'b100;
  localparam logic [2:0] LT_GREEN  = 3'b010;
  localparam logic [2:0] LT_YELLOW = 3'b001;

endpackage

// File: rtl/tlc_phase_timer.sv
// Phase down-counter: loads a duration-minus-one value, counts to zero and holds there.
module tlc_phase_timer #(
  parameter int              CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  assign done = (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= RST_VAL;
    else if (load)
      count <= load_val;
    else if (en && !done)
      count <= count - 1'b1;
  end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-approach intersection controller with demand-extended main green.
// Optional pedestrian walk phase is compiled in with `define TLC_PED_EN.
//
// state   | meaning
// MAIN_G  | main green, held until side or pedestrian demand after minimum green
// MAIN_Y  | main yellow
// ALLRED1 | clearance before side green
// SIDE_G  | side green, fixed length
// SIDE_Y  | side yellow
// ALLRED2 | clearance before main green or walk (reset state)
// WALK    | pedestrian walk, both heads red
module traffic_light_ctrl
  import tlc_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int GREEN_CYC  = 4,
  parameter int YELLOW_CYC = 2,
  parameter int ALLRED_CYC = 1,
  parameter int WALK_CYC   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       side_car,
  input  logic       ped_req,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk,
  output logic       ped_ack,
  output logic [2:0] phase
);

  if (GREEN_CYC < 1 || GREEN_CYC >= (1 << CNT_W) ||
      YELLOW_CYC < 1 || YELLOW_CYC >= (1 << CNT_W) ||
      ALLRED_CYC < 1 || ALLRED_CYC >= (1 << CNT_W) ||
      WALK_CYC < 1 || WALK_CYC >= (1 << CNT_W)) begin : g_bad_duration
    $error("traffic_light_ctrl: every duration must be >= 1 and fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] LD_GREEN  = CNT_W'(GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] LD_ALLRED = CNT_W'(ALLRED_CYC - 1);
  localparam logic [CNT_W-1:0] LD_WALK   = CNT_W'(WALK_CYC - 1);

  tlc_state_e       state, state_nx;
  logic             tmr_load, tmr_done;
  logic [CNT_W-1:0] tmr_load_val, unused_cnt;
  logic             side_pend, ped_pend;
  logic             enter_side;
  logic [2:0]       main_nx, side_nx;

  function automatic logic [CNT_W-1:0] load_for(input tlc_state_e s);
    case (s)
      MAIN_G, SIDE_G:   return LD_GREEN;
      MAIN_Y, SIDE_Y:   return LD_YELLOW;
      WALK:             return LD_WALK;
      default:          return LD_ALLRED;
    endcase
  endfunction

  // Timer reloads on every state change with the incoming state's duration
  assign tmr_load     = (state_nx != state);
  assign tmr_load_val = load_for(state_nx);

  tlc_phase_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (LD_ALLRED)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .en       (1'b1),
    .count    (unused_cnt),
    .done     (tmr_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= ALLRED2;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      MAIN_G:  if (tmr_done && (side_pend || ped_pend)) state_nx = MAIN_Y;
      MAIN_Y:  if (tmr_done) state_nx = ALLRED1;
      ALLRED1: if (tmr_done) state_nx = SIDE_G;
      SIDE_G:  if (tmr_done) state_nx = SIDE_Y;
      SIDE_Y:  if (tmr_done) state_nx = ALLRED2;
      ALLRED2: if (tmr_done) state_nx = ped_pend ? WALK : MAIN_G;
      WALK:    if (tmr_done) state_nx = MAIN_G;
      default: state_nx = ALLRED2;
    endcase
  end

  // Lamps are decoded from the next state so they switch on the same edge as the state
  always_comb begin
    main_nx = LT_RED;
    side_nx = LT_RED;
    case (state_nx)
      MAIN_G:  main_nx = LT_GREEN;
      MAIN_Y:  main_nx = LT_YELLOW;
      SIDE_G:  side_nx = LT_GREEN;
      SIDE_Y:  side_nx = LT_YELLOW;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_light <= LT_RED;
      side_light <= LT_RED;
    end else begin
      main_light <= main_nx;
      side_light <= side_nx;
    end
  end

  assign phase      = state;
  assign enter_side = (state_nx == SIDE_G) && (state != SIDE_G);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      side_pend <= 1'b0;
    else if (enter_side)
      side_pend <= 1'b0;
    else if (side_car && state != SIDE_G && state != SIDE_Y)
      side_pend <= 1'b1;
  end

`ifdef TLC_PED_EN
  logic enter_walk;

  assign enter_walk = (state_nx == WALK) && (state != WALK);

  // A request arriving on the walk-entry edge is served by that walk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ped_pend <= 1'b0;
    else if (enter_walk)
      ped_pend <= 1'b0;
    else if (ped_req)
      ped_pend <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      walk    <= 1'b0;
      ped_ack <= 1'b0;
    end else begin
      walk    <= (state_nx == WALK);
      ped_ack <= enter_walk;
    end
  end
`else
  logic unused_ped;

  assign unused_ped = ped_req;
  assign ped_pend   = 1'b0;
  assign walk       = 1'b0;
  assign ped_ack    = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Scoreboard bench for traffic_light_ctrl: a phase/age reference model predicts every cycle.
module tb_traffic_light_ctrl;
  import tlc_pkg::*;

  localparam int G  = 4;
  localparam int Y  = 2;
  localparam int AR = 1;
  localparam int WK = 3;
`ifdef TLC_PED_EN
  localparam bit PED = 1'b1;
`else
  localparam bit PED = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       side_car = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] main_light, side_light, phase;
  logic       walk, ped_ack;

  always #5 clk = ~clk;

  traffic_light_ctrl #(
    .CNT_W(8), .GREEN_CYC(G), .YELLOW_CYC(Y), .ALLRED_CYC(AR), .WALK_CYC(WK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .side_car(side_car), .ped_req(ped_req),
    .main_light(main_light), .side_light(side_light), .walk(walk),
    .ped_ack(ped_ack), .phase(phase)
  );

  typedef struct packed {
    logic [2:0] ml;
    logic [2:0] sl;
    logic       wk;
    logic       ack;
    logic [2:0] ph;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  // Reference model: current phase, cycles already spent in it, pending demand
  tlc_state_e m_ph = ALLRED2;
  int         m_age = 0;
  bit         m_sp = 1'b0, m_pp = 1'b0, m_ack = 1'b0;

  function automatic int dur(input tlc_state_e s);
    case (s)
      MAIN_G, SIDE_G: return G;
      MAIN_Y, SIDE_Y: return Y;
      WALK:           return WK;
      default:        return AR;
    endcase
  endfunction

  function automatic bit m_exits();
    return (m_age >= dur(m_ph) - 1) && (m_ph != MAIN_G || m_sp || m_pp);
  endfunction

  function automatic tlc_state_e after(input tlc_state_e s);
    case (s)
      MAIN_G:  return MAIN_Y;
      MAIN_Y:  return ALLRED1;
      ALLRED1: return SIDE_G;
      SIDE_G:  return SIDE_Y;
      SIDE_Y:  return ALLRED2;
      ALLRED2: return (PED && m_pp) ? WALK : MAIN_G;
      default: return MAIN_G;
    endcase
  endfunction

  function automatic exp_t expect_now();
    exp_t e;
    e.ml  = 3'b100;
    e.sl  = 3'b100;
    e.wk  = (m_ph == WALK);
    e.ack = m_ack;
    e.ph  = m_ph;
    if (m_ph == MAIN_G) e.ml = 3'b010;
    if (m_ph == MAIN_Y) e.ml = 3'b001;
    if (m_ph == SIDE_G) e.sl = 3'b010;
    if (m_ph == SIDE_Y) e.sl = 3'b001;
    return e;
  endfunction

  task automatic step(input bit rst, input bit sc, input bit pr);
    tlc_state_e nx;
    bit ex;
    if (!rst) begin
      m_ph = ALLRED2; m_age = 0; m_sp = 1'b0; m_pp = 1'b0; m_ack = 1'b0;
      return;
    end
    ex    = m_exits();
    nx    = ex ? after(m_ph) : m_ph;
    m_ack = PED && ex && (nx == WALK);
    if (ex && nx == SIDE_G) m_sp = 1'b0;
    else if (sc && m_ph != SIDE_G && m_ph != SIDE_Y) m_sp = 1'b1;
    if (ex && nx == WALK) m_pp = 1'b0;
    else if (PED && pr) m_pp = 1'b1;
    m_age = ex ? 0 : (m_age < 1000 ? m_age + 1 : m_age);
    m_ph  = nx;
  endtask

  task automatic cyc(input bit rst, input bit sc, input bit pr);
    @(negedge clk);
    rst_n    = rst;
    side_car = sc;
    ped_req  = pr;
    step(rst, sc, pr);
    q.push_back(expect_now());
  endtask

  // Monitor: one expectation per clock, sampled after the edge settles
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (main_light !== e.ml || side_light !== e.sl || walk !== e.wk ||
            ped_ack !== e.ack || phase !== e.ph) begin
          failures++;
          $display("FAIL cycle_cmp t=%0t got main=%b side=%b walk=%b ack=%b phase=%0d want main=%b side=%b walk=%b ack=%b phase=%0d",
                   $time, main_light, side_light, walk, ped_ack, phase,
                   e.ml, e.sl, e.wk, e.ack, e.ph);
        end
        checks++;
        if (main_light == 3'b010 && side_light == 3'b010) begin
          failures++;
          $display("FAIL conflict_green t=%0t got main=%b side=%b want not both 010",
                   $time, main_light, side_light);
        end
      end
    end
  end

  initial begin
    int guard;
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    repeat (50) cyc(1'b1, 1'b0, 1'b0);

    cyc(1'b1, 1'b1, 1'b0);
    repeat (30) cyc(1'b1, 1'b0, 1'b0);

    cyc(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++)
      cyc(1'b1, 1'b0, PED && m_ph == ALLRED2 && m_pp && m_exits());

    for (int i = 0; i < 60; i++)
      cyc(1'b1, 1'b1, ($urandom_range(0, 9) == 0));

    cyc(1'b1, 1'b1, 1'b0);
    guard = 0;
    while (m_ph != SIDE_G && guard < 30) begin
      cyc(1'b1, 1'b0, 1'b0);
      guard++;
    end
    cyc(1'b1, 1'b0, 1'b0);
    repeat (2) cyc(1'b0, 1'b0, 1'b0);
    repeat (20) cyc(1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 800; i++)
      cyc(($urandom_range(0, 199) != 0), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 15) == 0));

    repeat (5) begin
      if (q.size() > 0) @(negedge clk);
    end
    if (q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain got pending=%0d want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
